// File: rtl/if_mem_ctrl.sv
// -----------------------------------------------------------------------------
// if_mem_ctrl
//
// Instruction-fetch responder on the memory side of the IF request/done
// handshake. On a request whose PC is not the buffered one, it reads
// INST_BYTES bytes from a byte-wide RAM and assembles them little-endian.
// It holds if_done high for as long as the requested PC matches the PC it
// fetched. It only ever reads the RAM.
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   if_request  fetch request from the IF stage
//   if_pc       PC of the requested instruction
//   if_done     if_inst is valid for if_pc (combinational hit)
//   if_inst     assembled instruction, zero when if_done is low
//   mem_din     RAM read data: the byte addressed in the previous cycle
//   mem_a       RAM byte address, zero when no read is in progress
//   mem_wr      RAM write enable, tied low
// -----------------------------------------------------------------------------
module if_mem_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_BYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_request,
   input  logic [ADDR_WIDTH-1:0] if_pc,
   output logic                  if_done,
   output logic [31:0]           if_inst,
   input  logic [7:0]            mem_din,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic                  mem_wr
);

   localparam int CNT_W = $clog2(INST_BYTES + 1);
   localparam int BUF_W = 8 * INST_BYTES;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INST_BYTES);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t                  state_reg, state_next;
   logic [CNT_W-1:0]        cnt_reg, cnt_next;
   logic                    valid_reg, valid_next;
   logic [ADDR_WIDTH-1:0]   fetch_pc_reg, fetch_pc_next;
   logic [ADDR_WIDTH-1:0]   tag_pc_reg, tag_pc_next;
   logic [ADDR_WIDTH-1:0]   mem_a_busy;
   logic [BUF_W-1:0]        inst_buf;
   logic [31:0]             inst_word;
   logic                    hit;
   logic                    redirect;
   logic                    capture;

   // The buffered word answers the IF stage only while its PC is requested.
   assign hit      = valid_reg && (tag_pc_reg == if_pc);

   // A request for a different PC while reading abandons the partial word.
   assign redirect = (state_reg == BUSY) && if_request && (if_pc != fetch_pc_reg);

   // mem_din carries the byte addressed one cycle earlier, so byte k of the
   // word arrives when cnt == k+1. A redirecting cycle captures nothing.
   assign capture  = (state_reg == BUSY) && (cnt_reg != '0) && !redirect;

   // ---------------------------------------------------------------------
   // Instruction buffer: one register per byte lane, each loaded in the
   // cycle its byte returns from the RAM.
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < INST_BYTES; gi++) begin : g_lane
         logic [7:0] lane_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               lane_reg <= '0;
            end else if (capture && (cnt_reg == CNT_W'(gi + 1))) begin
               lane_reg <= mem_din;
            end
         end

         assign inst_buf[8*gi +: 8] = lane_reg;
      end

      if (BUF_W >= 32) begin : g_word_trunc
         assign inst_word = inst_buf[31:0];
      end else begin : g_word_pad
         assign inst_word = {{(32 - BUF_W){1'b0}}, inst_buf};
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Control state
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         valid_reg    <= 1'b0;
         fetch_pc_reg <= '0;
         tag_pc_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         valid_reg    <= valid_next;
         fetch_pc_reg <= fetch_pc_next;
         tag_pc_reg   <= tag_pc_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      valid_next    = valid_reg;
      fetch_pc_next = fetch_pc_reg;
      tag_pc_next   = tag_pc_reg;
      mem_a_busy    = '0;

      case (state_reg)
         IDLE: begin
            if (if_request && !hit) begin
               // Miss: the old word is no longer trusted once a new read starts.
               fetch_pc_next = if_pc;
               cnt_next      = '0;
               valid_next    = 1'b0;
               state_next    = BUSY;
            end
         end

         BUSY: begin
            // Address arithmetic wraps at the top of the address space.
            if (cnt_reg < CNT_LAST) begin
               mem_a_busy = fetch_pc_reg + ADDR_WIDTH'(cnt_reg);
            end

            if (redirect) begin
               // Restart for the new PC; this also wins over completion,
               // so an abandoned word never becomes valid.
               fetch_pc_next = if_pc;
               cnt_next      = '0;
            end else if (cnt_reg == CNT_LAST) begin
               // Last byte is captured this cycle by the lane registers.
               valid_next  = 1'b1;
               tag_pc_next = fetch_pc_reg;
               cnt_next    = '0;
               state_next  = IDLE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Outputs: all quiet while reset is asserted.
   // ---------------------------------------------------------------------
   assign if_done = if_request && hit && !rst;
   assign if_inst = if_done ? inst_word : 32'd0;
   assign mem_a   = rst ? '0 : mem_a_busy;
   assign mem_wr  = 1'b0;

endmodule
